// File: rtl/instr_fetch_unit.sv
// RV32I instruction fetch: PC register, single-outstanding imem request/grant/response,
// one-entry valid/ready buffer toward the decoder, redirect handling with stale-response drain.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        misalign
);

  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        consume;
  logic        buf_free;
  logic        accept;

  assign consume   = instr_valid & instr_ready;
  assign buf_free  = ~instr_valid | instr_ready;
  // Request is masked while reset is held so the bus stays quiet during reset.
  assign imem_req  = rst_n & (state == FETCH) & buf_free;
  assign imem_addr = pc;
  assign accept    = imem_req & imem_gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
      misalign    <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect flushes the buffer; any granted or pending response becomes stale.
      pc          <= {redirect_pc[31:2], 2'b00};
      instr_valid <= 1'b0;
      misalign    <= |redirect_pc[1:0];
      case (state)
        FETCH:   state <= accept ? DRAIN : FETCH;
        WAIT:    state <= imem_rvalid ? FETCH : DRAIN;
        DRAIN:   state <= imem_rvalid ? FETCH : DRAIN;
        default: state <= FETCH;
      endcase
    end else begin
      misalign <= 1'b0;
      if (consume) instr_valid <= 1'b0;
      case (state)
        FETCH: begin
          if (accept) state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc + 32'd4;
            state       <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_rvalid) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed table-driven bench for instr_fetch_unit: one instance at RESET_PC=0 for the
// main vectors, one at RESET_PC=FFFF_FFFC for wrap and reset-during-WAIT sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, imem_gnt, imem_rvalid, redirect_valid, instr_ready;
  logic [31:0] imem_rdata, redirect_pc;

  logic        req0, iv0, mis0, req1, iv1, mis1;
  logic [31:0] addr0, ins0, ipc0, addr1, ins1, ipc1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .imem_req(req0), .imem_addr(addr0), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(iv0), .instr(ins0), .instr_pc(ipc0),
    .instr_ready(instr_ready), .misalign(mis0));

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst_n(rst_n), .imem_req(req1), .imem_addr(addr1), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(iv1), .instr(ins1), .instr_pc(ipc1),
    .instr_ready(instr_ready), .misalign(mis1));

  typedef struct {
    logic        rst_n, gnt, rvalid;
    logic [31:0] rdata;
    logic        ready, rdv;
    logic [31:0] rdpc;
    logic        req;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ins, ipc;
    logic        mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic g, logic rv, logic [31:0] rd, logic rdy,
                              logic rdv, logic [31:0] rdpc, logic req, logic [31:0] addr,
                              logic iv, logic [31:0] ins, logic [31:0] ipc, logic mis);
    vec_t v;
    v.rst_n = r; v.gnt = g; v.rvalid = rv; v.rdata = rd; v.ready = rdy;
    v.rdv = rdv; v.rdpc = rdpc; v.req = req; v.addr = addr; v.iv = iv;
    v.ins = ins; v.ipc = ipc; v.mis = mis;
    return v;
  endfunction

  task automatic drive(logic r, logic g, logic rv, logic [31:0] rd, logic rdy,
                       logic rdv, logic [31:0] rdpc);
    rst_n = r; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
    instr_ready = rdy; redirect_valid = rdv; redirect_pc = rdpc;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Address is compared only when a request is expected; it is don't-care otherwise.
  task automatic chk(string nm, logic a_req, logic [31:0] a_addr, logic a_iv,
                     logic [31:0] a_ins, logic [31:0] a_ipc, logic a_mis,
                     logic e_req, logic [31:0] e_addr, logic e_iv,
                     logic [31:0] e_ins, logic [31:0] e_ipc, logic e_mis);
    logic ok;
    ok = (a_req === e_req) && (!e_req || a_addr === e_addr) && (a_iv === e_iv) &&
         (a_ins === e_ins) && (a_ipc === e_ipc) && (a_mis === e_mis);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got req=%b addr=%h iv=%b instr=%h pc=%h mis=%b, want req=%b addr=%h iv=%b instr=%h pc=%h mis=%b",
               nm, a_req, a_addr, a_iv, a_ins, a_ipc, a_mis,
               e_req, e_addr, e_iv, e_ins, e_ipc, e_mis);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //              rst g rv rdata          rdy rdv rdpc           req addr           iv instr          pc             mis
    vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(1, 0, 1, 32'h1000_0000, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0,         0));
    vecs.push_back(mk(1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h4,         1, 32'h1000_0000, 32'h0,         0));
    vecs.push_back(mk(1, 0, 1, 32'h1000_0004, 1, 0, 32'h0,         0, 32'h0,         0, 32'h1000_0000, 32'h0,         0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 1, 0, 32'h0,       0, 0, 32'h0,         0, 32'h0,         1, 32'h1000_0004, 32'h4,         0));
    vecs.push_back(mk(1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h8,         1, 32'h1000_0004, 32'h4,         0));
    vecs.push_back(mk(1, 0, 1, 32'h1000_0008, 1, 0, 32'h0,         0, 32'h0,         0, 32'h1000_0004, 32'h4,         0));
    vecs.push_back(mk(1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'hC,         1, 32'h1000_0008, 32'h8,         0));
    vecs.push_back(mk(1, 0, 1, 32'h1000_000C, 1, 0, 32'h0,         0, 32'h0,         0, 32'h1000_0008, 32'h8,         0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h10,        1, 32'h1000_000C, 32'hC,         0));
    vecs.push_back(mk(1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h10,        0, 32'h1000_000C, 32'hC,         0));
    // redirect in WAIT, stale DEADBEEF arrives three cycles later
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 1, 32'h100,       0, 32'h0,         0, 32'h1000_000C, 32'hC,         0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         0, 32'h1000_000C, 32'hC,         0));
    vecs.push_back(mk(1, 1, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         0, 32'h1000_000C, 32'hC,         0));
    vecs.push_back(mk(1, 0, 1, 32'hDEAD_BEEF, 1, 0, 32'h0,         0, 32'h0,         0, 32'h1000_000C, 32'hC,         0));
    vecs.push_back(mk(1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h100,       0, 32'h1000_000C, 32'hC,         0));
    vecs.push_back(mk(1, 0, 1, 32'h2000_0100, 1, 0, 32'h0,         0, 32'h0,         0, 32'h1000_000C, 32'hC,         0));
    // redirect coincident with req & gnt
    vecs.push_back(mk(1, 1, 0, 32'h0,         1, 1, 32'h200,       1, 32'h104,       1, 32'h2000_0100, 32'h100,       0));
    vecs.push_back(mk(1, 1, 1, 32'hDEAD_0104, 1, 0, 32'h0,         0, 32'h0,         0, 32'h2000_0100, 32'h100,       0));
    vecs.push_back(mk(1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h200,       0, 32'h2000_0100, 32'h100,       0));
    // misaligned redirect coincident with rvalid
    vecs.push_back(mk(1, 0, 1, 32'hDEAD_0200, 1, 1, 32'h102,       0, 32'h0,         0, 32'h2000_0100, 32'h100,       0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h100,       0, 32'h2000_0100, 32'h100,       1));
    vecs.push_back(mk(1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h100,       0, 32'h2000_0100, 32'h100,       0));
    vecs.push_back(mk(1, 0, 1, 32'h3000_0100, 1, 0, 32'h0,         0, 32'h0,         0, 32'h2000_0100, 32'h100,       0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h3000_0100, 32'h100,       0));
    // redirect in FETCH with a full, unconsumed buffer
    vecs.push_back(mk(1, 0, 0, 32'h0,         0, 1, 32'h400,       0, 32'h0,         1, 32'h3000_0100, 32'h100,       0));
    vecs.push_back(mk(1, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h400,       0, 32'h3000_0100, 32'h100,       0));
    vecs.push_back(mk(1, 0, 1, 32'h3000_0400, 0, 0, 32'h0,         0, 32'h0,         0, 32'h3000_0100, 32'h100,       0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h3000_0400, 32'h400,       0));

    drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata,
            vecs[i].ready, vecs[i].rdv, vecs[i].rdpc);
      #1;
      chk($sformatf("vec%0d", i), req0, addr0, iv0, ins0, ipc0, mis0,
          vecs[i].req, vecs[i].addr, vecs[i].iv, vecs[i].ins, vecs[i].ipc, vecs[i].mis);
      tick();
    end

    // PC wrap from FFFF_FFFC, then reset asserted while in WAIT
    drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
    tick();
    drive(1, 1, 0, 32'h0, 1, 0, 32'h0); #1;
    chk("wrap_req0", req1, addr1, iv1, ins1, ipc1, mis1, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0);
    tick();
    drive(1, 0, 1, 32'h5555_0001, 1, 0, 32'h0); #1;
    chk("wrap_wait", req1, addr1, iv1, ins1, ipc1, mis1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    tick();
    drive(1, 1, 0, 32'h0, 1, 0, 32'h0); #1;
    chk("wrap_req1", req1, addr1, iv1, ins1, ipc1, mis1, 1, 32'h0, 1, 32'h5555_0001, 32'hFFFF_FFFC, 0);
    tick();
    drive(0, 0, 0, 32'h0, 1, 0, 32'h0); #1;
    chk("rst_in_wait", req1, addr1, iv1, ins1, ipc1, mis1, 0, 32'h0, 0, 32'h5555_0001, 32'hFFFF_FFFC, 0);
    tick();
    drive(1, 0, 1, 32'h6666_6666, 1, 0, 32'h0); #1;
    chk("post_rst", req1, addr1, iv1, ins1, ipc1, mis1, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0);
    tick();
    drive(1, 0, 0, 32'h0, 1, 0, 32'h0); #1;
    chk("late_rvalid", req1, addr1, iv1, ins1, ipc1, mis1, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the single-issue RV32I core, directly upstream of the control unit (decoder). Holds the program counter, issues one word read at a time to instruction memory over a request/grant/response handshake, and presents each fetched instruction with its PC to the decoder through a one-entry valid/ready output buffer. It also accepts PC redirects from branch/JAL/JALR resolution and discards any in-flight response made stale by a redirect.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset (must be word aligned)
- clk  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- imem_req  output  1  read request valid
- imem_addr  output  32  word-aligned read address; held stable while imem_req=1 and imem_gnt=0
- imem_gnt  input  1  memory accepts the request this cycle
- imem_rvalid  input  1  read data valid; at least 1 cycle after the accepting gnt
- imem_rdata  input  32  instruction word, sampled when imem_rvalid=1
- redirect_valid  input  1  single-cycle PC redirect (taken branch, JAL, JALR)
- redirect_pc  input  32  redirect target
- instr_valid  output  1  output buffer holds a valid instruction
- instr  output  32  instruction to the decoder
- instr_pc  output  32  PC of instr
- instr_ready  input  1  decoder consumes instr this cycle when instr_valid=1
- misalign  output  1  one-cycle pulse: redirect_pc[1:0] != 0 was received

## Operation
- State machine: FETCH, WAIT, DRAIN.
- FETCH: imem_req=1, imem_addr=pc, only when the output buffer is empty or is being consumed this cycle (instr_valid & instr_ready); otherwise imem_req=0 and stay. imem_req & imem_gnt -> WAIT.
- WAIT: imem_req=0. On imem_rvalid: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0), -> FETCH.
- DRAIN: imem_req=0; one stale response outstanding. On imem_rvalid: drop data, buffer unchanged, -> FETCH.
- Output buffer: instr_valid clears on instr_valid & instr_ready unless reloaded the same cycle; instr/instr_pc hold while instr_valid=1 and instr_ready=0.
- Redirect (highest priority, any state): pc<={redirect_pc[31:2],2'b00}; instr_valid<=0 (buffer flushed, including any same-cycle load); misalign<=|redirect_pc[1:0].
  - In FETCH with imem_req&imem_gnt same cycle -> DRAIN (granted request is stale).
  - In FETCH without grant -> FETCH; next request uses the new pc.
  - In WAIT without rvalid -> DRAIN. In WAIT with rvalid that cycle -> FETCH, data dropped.
  - In DRAIN: pc updated; stays DRAIN unless rvalid that cycle (-> FETCH, data dropped).
- At most one request outstanding at any time.

## Timing
- Reset (rst_n=0 sampled at edge): state=FETCH, pc=RESET_PC, instr_valid=0, instr=0, instr_pc=0, misalign=0. imem_req is combinational from state/buffer: =1 the first cycle after rst_n deasserts. Reset mid-transaction abandons the outstanding request; a response arriving after reset while in FETCH is ignored.
- imem_req/imem_addr are combinational from registered state; no combinational path from imem_rdata to outputs.
- Fetch latency: gnt in cycle n, rvalid in cycle n+k (k≥1), instr_valid=1 from cycle n+k+1.
- Best-case throughput with k=1 and instr_ready=1: one instruction per 2 cycles.
- Redirect in cycle n: instr_valid=0 in cycle n+1; first request at new pc in cycle n+1 (if no stale response outstanding) or the cycle after the stale rvalid.
- misalign high exactly one cycle (n+1) per misaligned redirect.

## Test plan
- Reset, RESET_PC=0, memory gnt same cycle, rvalid 1 cycle later, instr_ready=1 -> imem_addr sequence 0,4,8,12; instr_pc matches; instr_valid pulses every 2 cycles; outputs all 0 during reset.
- Backpressure: instr_ready=0 for 5 cycles with instr at PC 4 held -> instr/instr_pc stable, no imem_req while buffer full and not consumed; resumes with addr 8 on the cycle instr_ready=1.
- Redirect in WAIT to 32'h100 with rvalid 3 cycles later carrying 32'hDEAD_BEEF -> that word never appears on instr; next request addr 32'h100; first valid instr_pc=32'h100.
- Redirect coincident with imem_req&imem_gnt, and separately coincident with imem_rvalid -> stale data dropped in both, no double outstanding requests, next addr = target.
- Redirect to 32'h0000_0102 -> misalign=1 for one cycle, next imem_addr=32'h0000_0100.
- PC wrap: RESET_PC=32'hFFFF_FFFC -> second fetch addr 32'h0000_0000; rst_n=0 asserted while in WAIT -> FETCH at RESET_PC next cycle after release, late rvalid ignored.
